// File: rtl/gon_pkg.sv
// gon_pkg: shared defaults and types for the GON column gather bus.
// Holds the default widths, the psum/column-ID typedefs and the helper
// that sizes the source-column index.
package gon_pkg;

   localparam int unsigned DATA_WIDTH    = 64;
   localparam int unsigned COL_TAG_WIDTH = 4;
   localparam int unsigned NUM_OF_COLS   = 14;

   // Index width for n columns, never narrower than one bit
   function automatic int unsigned src_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned SRC_WIDTH = src_width(NUM_OF_COLS);

   typedef logic [DATA_WIDTH-1:0]    psum_t;
   typedef logic [COL_TAG_WIDTH-1:0] col_id_t;

endpackage : gon_pkg

// File: rtl/gon_xbus_if.sv
// gon_xbus_if: column-side and Y-bus-side handshake bundle of the gather bus.
//   data_in/enable_in/ready_out : per-column psum offer and accept
//   col_tag                     : requested column ID from the GON controller
//   data_out/enable_out/ready_in: registered gathered word toward the Y-bus
//   out_col                     : index of the column that supplied data_out
// Modports: slave = gather bus, master = columns/controller/Y-bus side.
interface gon_xbus_if #(
   parameter int unsigned DATA_WIDTH    = gon_pkg::DATA_WIDTH,
   parameter int unsigned COL_TAG_WIDTH = gon_pkg::COL_TAG_WIDTH,
   parameter int unsigned NUM_OF_COLS   = gon_pkg::NUM_OF_COLS,
   parameter int unsigned SRC_WIDTH     = gon_pkg::src_width(NUM_OF_COLS)
);
   import gon_pkg::*;

   logic [DATA_WIDTH-1:0]    data_in [0:NUM_OF_COLS-1];
   logic [0:NUM_OF_COLS-1]   enable_in;
   logic [0:NUM_OF_COLS-1]   ready_out;
   logic [COL_TAG_WIDTH-1:0] col_tag;
   logic [DATA_WIDTH-1:0]    data_out;
   logic                     enable_out;
   logic                     ready_in;
   logic [SRC_WIDTH-1:0]     out_col;

   modport slave (
      input  data_in, enable_in, col_tag, ready_in,
      output ready_out, data_out, enable_out, out_col
   );

   modport master (
      output data_in, enable_in, col_tag, ready_in,
      input  ready_out, data_out, enable_out, out_col
   );

endinterface : gon_xbus_if

// File: rtl/gon_col_arbiter.sv
// gon_col_arbiter: picks one column among the matching ones.
//   clk, rst    : clock, async active-high reset (round-robin pointer only)
//   match       : per-column match vector (bit i = column i)
//   xfer        : a transfer from the granted column happens this edge
//   grant       : selected column index
//   grant_valid : at least one column matches
// Optional macro GON_RR_ARB_EN: round-robin from rr_ptr instead of fixed
// lowest-index priority.
module gon_col_arbiter #(
   parameter int unsigned NUM_OF_COLS = gon_pkg::NUM_OF_COLS,
   parameter int unsigned SRC_WIDTH   = gon_pkg::src_width(NUM_OF_COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_OF_COLS-1:0] match,
   input  logic                   xfer,
   output logic [SRC_WIDTH-1:0]   grant,
   output logic                   grant_valid
);
   import gon_pkg::*;

`ifdef GON_RR_ARB_EN
   logic [SRC_WIDTH-1:0] rr_ptr;
   int                   idx;

   // Search starts at rr_ptr; scanning offsets high to low lets the
   // smallest offset win without a break
   always_comb begin
      grant       = '0;
      grant_valid = |match;
      idx         = 0;
      for (int k = int'(NUM_OF_COLS) - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= int'(NUM_OF_COLS)) idx = idx - int'(NUM_OF_COLS);
         if (match[idx]) grant = SRC_WIDTH'(idx);
      end
   end

   // Pointer moves just past the column that was served
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (grant == SRC_WIDTH'(NUM_OF_COLS - 1)) ? '0 : grant + 1'b1;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = ^{clk, rst, xfer};

   // Fixed priority: lowest matching index wins
   always_comb begin
      grant       = '0;
      grant_valid = |match;
      for (int i = int'(NUM_OF_COLS) - 1; i >= 0; i--) begin
         if (match[i]) grant = SRC_WIDTH'(i);
      end
   end
`endif

endmodule : gon_col_arbiter

// File: rtl/gon_xbus.sv
// gon_xbus: GON column gather bus. Forwards one psum word per transfer from
// the column whose scan-loaded ID equals col_tag into a single-entry
// registered output stage toward the GLB-side Y-bus.
//   clk, reset  : clock, async active-high reset
//   bus         : gon_xbus_if.slave (column offers, col_tag, output stage)
//   scan_en_id  : shift the column-ID chain one bit per edge, blocks transfers
//   scan_in_id  : chain input into LSB of column 0's ID
//   scan_out_id : MSB of the last column's ID
// Optional macro GON_RR_ARB_EN: round-robin arbitration among duplicates.
module gon_xbus #(
   parameter int unsigned DATA_WIDTH    = gon_pkg::DATA_WIDTH,
   parameter int unsigned COL_TAG_WIDTH = gon_pkg::COL_TAG_WIDTH,
   parameter int unsigned NUM_OF_COLS   = gon_pkg::NUM_OF_COLS,
   parameter int unsigned SRC_WIDTH     = gon_pkg::src_width(NUM_OF_COLS)
) (
   input  logic        clk,
   input  logic        reset,
   gon_xbus_if.slave   bus,
   input  logic        scan_en_id,
   input  logic        scan_in_id,
   output logic        scan_out_id
);
   import gon_pkg::*;

   logic [COL_TAG_WIDTH-1:0] col_id [NUM_OF_COLS];
   logic [NUM_OF_COLS-1:0]   match;
   logic [SRC_WIDTH-1:0]     grant;
   logic                     grant_valid;
   logic                     can_accept;
   logic                     xfer;

   // Column-ID scan chain: bits enter column 0 and ripple toward the last column
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_OF_COLS); i++) col_id[i] <= '0;
      end else if (scan_en_id) begin
         col_id[0] <= {col_id[0][COL_TAG_WIDTH-2:0], scan_in_id};
         for (int i = 1; i < int'(NUM_OF_COLS); i++) begin
            col_id[i] <= {col_id[i][COL_TAG_WIDTH-2:0], col_id[i-1][COL_TAG_WIDTH-1]};
         end
      end
   end

   assign scan_out_id = col_id[NUM_OF_COLS-1][COL_TAG_WIDTH-1];

   // A column is a candidate only while it is offering and its ID is requested
   always_comb begin
      match = '0;
      for (int i = 0; i < int'(NUM_OF_COLS); i++) begin
         match[i] = bus.enable_in[i] && (col_id[i] == bus.col_tag);
      end
   end

   gon_col_arbiter #(
      .NUM_OF_COLS (NUM_OF_COLS),
      .SRC_WIDTH   (SRC_WIDTH)
   ) u_arb (
      .clk         (clk),
      .rst         (reset),
      .match       (match),
      .xfer        (xfer),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Output stage accepts when empty or draining this edge
   assign can_accept = !bus.enable_out || bus.ready_in;
   assign xfer       = !reset && !scan_en_id && can_accept && grant_valid;

   // Only the granted column sees ready; enable_in is already folded into match
   always_comb begin
      bus.ready_out = '0;
      if (xfer) bus.ready_out[grant] = 1'b1;
   end

   // Single-entry output register; a fill on a draining edge replaces the word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.enable_out <= 1'b0;
         bus.data_out   <= '0;
         bus.out_col    <= '0;
      end else if (xfer) begin
         bus.enable_out <= 1'b1;
         bus.data_out   <= bus.data_in[grant];
         bus.out_col    <= grant;
      end else if (bus.ready_in) begin
         bus.enable_out <= 1'b0;
      end
   end

endmodule : gon_xbus

// File: tb/tb_gon_xbus.sv
// tb_gon_xbus: directed self-checking bench for gon_xbus.
module tb_gon_xbus;
   import gon_pkg::*;

   localparam int unsigned NC = NUM_OF_COLS;
   localparam int unsigned TW = COL_TAG_WIDTH;
   localparam int unsigned DW = DATA_WIDTH;

   logic clk = 1'b0;
   logic reset;
   logic scan_en_id;
   logic scan_in_id;
   logic scan_out_id;

   gon_xbus_if bus ();

   gon_xbus dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .scan_en_id  (scan_en_id),
      .scan_in_id  (scan_in_id),
      .scan_out_id (scan_out_id)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [TW-1:0] ids [NC];
   logic          seq [NC*TW];

   typedef struct {
      logic [0:NC-1] en;
      logic [TW-1:0] tag;
      logic          rdy;
      logic [0:NC-1] exp_ready;
      logic          exp_eo;
      int unsigned   exp_col;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [0:NC-1] oh(input int i);
      logic [0:NC-1] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // First-shifted bits land in the last column, so shift column NC-1 MSB first
   task automatic load_ids(input logic check_replay);
      int j;
      j = 0;
      for (int c = int'(NC) - 1; c >= 0; c--) begin
         for (int b = int'(TW) - 1; b >= 0; b--) begin
            seq[j] = ids[c][b];
            j++;
         end
      end
      scan_en_id = 1'b1;
      for (int k = 0; k < int'(NC * TW); k++) begin
         scan_in_id = seq[k];
         #1;
         if (check_replay) chk("scan_replay", 64'(scan_out_id), 64'(seq[k]));
         tick();
      end
      scan_en_id = 1'b0;
      scan_in_id = 1'b0;
   endtask

   task automatic drain();
      bus.enable_in = '0;
      bus.ready_in  = 1'b1;
      tick();
   endtask

   initial begin : main
      logic [0:NC-1] exp5;
      logic [0:NC-1] all_en;
      int unsigned   exp_c;

      exp5   = 14'b00000100000000;
      all_en = '1;

      reset         = 1'b1;
      scan_en_id    = 1'b0;
      scan_in_id    = 1'b0;
      bus.col_tag   = '0;
      bus.enable_in = all_en;
      bus.ready_in  = 1'b0;
      for (int i = 0; i < int'(NC); i++) bus.data_in[i] = DW'(4096 + i);

      // Reset state
      #2;
      chk("rst_enable_out", 64'(bus.enable_out), 64'd0);
      chk("rst_data_out", 64'(bus.data_out), 64'd0);
      chk("rst_out_col", 64'(bus.out_col), 64'd0);
      chk("rst_ready_out", 64'(bus.ready_out), 64'd0);
      chk("rst_scan_out", 64'(scan_out_id), 64'd0);
      tick();
      chk("rst_hold_enable_out", 64'(bus.enable_out), 64'd0);
      @(negedge clk);
      reset         = 1'b0;
      bus.enable_in = '0;
      tick();

      // Scan load col k <- ID k, then replay the chain through scan_out_id
      for (int c = 0; c < int'(NC); c++) ids[c] = TW'(c);
      load_ids(1'b0);
      load_ids(1'b1);

      bus.col_tag   = TW'(5);
      bus.enable_in = oh(5);
      bus.ready_in  = 1'b1;
      #1;
      chk("tag5_ready", 64'(bus.ready_out), 64'(exp5));
      bus.enable_in = oh(4);
      #1;
      chk("tag5_not_offering", 64'(bus.ready_out), 64'd0);

      // Table-driven single transfers from an empty output stage
      vecs[0] = '{en: oh(3),         tag: TW'(3),  rdy: 1'b1, exp_ready: oh(3),  exp_eo: 1'b1, exp_col: 3};
      vecs[1] = '{en: oh(5),         tag: TW'(3),  rdy: 1'b1, exp_ready: '0,     exp_eo: 1'b0, exp_col: 0};
      vecs[2] = '{en: all_en,        tag: TW'(13), rdy: 1'b1, exp_ready: oh(13), exp_eo: 1'b1, exp_col: 13};
      vecs[3] = '{en: all_en,        tag: TW'(15), rdy: 1'b1, exp_ready: '0,     exp_eo: 1'b0, exp_col: 0};
      vecs[4] = '{en: oh(0) | oh(7), tag: TW'(7),  rdy: 1'b0, exp_ready: oh(7),  exp_eo: 1'b1, exp_col: 7};
      vecs[5] = '{en: '0,            tag: TW'(0),  rdy: 1'b1, exp_ready: '0,     exp_eo: 1'b0, exp_col: 0};
      vecs[6] = '{en: oh(0),         tag: TW'(0),  rdy: 1'b1, exp_ready: oh(0),  exp_eo: 1'b1, exp_col: 0};
      vecs[7] = '{en: all_en,        tag: TW'(0),  rdy: 1'b1, exp_ready: oh(0),  exp_eo: 1'b1, exp_col: 0};

      for (int v = 0; v < 8; v++) begin
         drain();
         bus.enable_in = vecs[v].en;
         bus.col_tag   = vecs[v].tag;
         bus.ready_in  = vecs[v].rdy;
         #1;
         chk($sformatf("vec%0d_ready", v), 64'(bus.ready_out), 64'(vecs[v].exp_ready));
         tick();
         chk($sformatf("vec%0d_enable_out", v), 64'(bus.enable_out), 64'(vecs[v].exp_eo));
         if (vecs[v].exp_eo) begin
            chk($sformatf("vec%0d_out_col", v), 64'(bus.out_col), 64'(vecs[v].exp_col));
            chk($sformatf("vec%0d_data_out", v), 64'(bus.data_out), 64'(4096 + vecs[v].exp_col));
         end
      end

      // Basic gather
      drain();
      bus.data_in[3] = DW'(64'hA5);
      bus.col_tag    = TW'(3);
      bus.enable_in  = oh(3);
      bus.ready_in   = 1'b1;
      tick();
      chk("gather_enable_out", 64'(bus.enable_out), 64'd1);
      chk("gather_data_out", 64'(bus.data_out), 64'hA5);
      chk("gather_out_col", 64'(bus.out_col), 64'd3);

      // Backpressure holds the word, then drain and fill on the same edge
      bus.ready_in   = 1'b0;
      bus.data_in[3] = DW'(64'hB6);
      #1;
      chk("bp_ready_low", 64'(bus.ready_out), 64'd0);
      tick();
      chk("bp_hold_data", 64'(bus.data_out), 64'hA5);
      chk("bp_hold_enable", 64'(bus.enable_out), 64'd1);
      tick();
      chk("bp_hold_data2", 64'(bus.data_out), 64'hA5);
      bus.ready_in = 1'b1;
      #1;
      chk("bp_release_ready", 64'(bus.ready_out), 64'(oh(3)));
      tick();
      chk("bp_new_data", 64'(bus.data_out), 64'hB6);
      chk("bp_new_enable", 64'(bus.enable_out), 64'd1);
      chk("bp_new_col", 64'(bus.out_col), 64'd3);
      bus.enable_in = '0;
      tick();
      chk("bp_empty", 64'(bus.enable_out), 64'd0);

      // Duplicate IDs: columns 2 and 9 both carry ID 7
      for (int c = 0; c < int'(NC); c++) ids[c] = TW'(c);
      ids[2] = TW'(7);
      ids[9] = TW'(7);
      load_ids(1'b0);
      bus.col_tag   = TW'(0);
      bus.enable_in = oh(0);
      bus.ready_in  = 1'b1;
      tick();
      chk("dup_prime_col", 64'(bus.out_col), 64'd0);
      bus.col_tag   = TW'(7);
      bus.enable_in = oh(2) | oh(9);
      for (int k = 0; k < 4; k++) begin
         tick();
`ifdef GON_RR_ARB_EN
         exp_c = (k % 2 == 0) ? 2 : 9;
`else
         exp_c = 2;
`endif
         chk($sformatf("dup%0d_enable_out", k), 64'(bus.enable_out), 64'd1);
         chk($sformatf("dup%0d_out_col", k), 64'(bus.out_col), 64'(exp_c));
         chk($sformatf("dup%0d_data_out", k), 64'(bus.data_out), 64'(4096 + exp_c));
      end
      drain();

      // Scan shifting blocks new transfers but lets a held word drain
      bus.col_tag   = TW'(3);
      bus.enable_in = oh(3);
      bus.ready_in  = 1'b0;
      tick();
      chk("scanblk_loaded", 64'(bus.enable_out), 64'd1);
      scan_en_id = 1'b1;
      #1;
      chk("scanblk_ready0", 64'(bus.ready_out), 64'd0);
      tick();
      chk("scanblk_hold_data", 64'(bus.data_out), 64'hB6);
      bus.ready_in = 1'b1;
      #1;
      chk("scanblk_ready1", 64'(bus.ready_out), 64'd0);
      tick();
      chk("scanblk_drained", 64'(bus.enable_out), 64'd0);
      scan_en_id = 1'b0;

      // Async reset between edges drops the held word and clears IDs
      for (int c = 0; c < int'(NC); c++) ids[c] = TW'(c);
      load_ids(1'b0);
      bus.col_tag   = TW'(4);
      bus.enable_in = oh(4);
      bus.ready_in  = 1'b0;
      tick();
      chk("arst_pre_enable", 64'(bus.enable_out), 64'd1);
      #2;
      reset         = 1'b1;
      bus.col_tag   = TW'(0);
      bus.enable_in = all_en;
      #1;
      chk("arst_enable_out", 64'(bus.enable_out), 64'd0);
      chk("arst_data_out", 64'(bus.data_out), 64'd0);
      chk("arst_out_col", 64'(bus.out_col), 64'd0);
      chk("arst_scan_out", 64'(scan_out_id), 64'd0);
      chk("arst_ready_out", 64'(bus.ready_out), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 64'(bus.ready_out), 64'(oh(0)));
      tick();
      chk("post_rst_col", 64'(bus.out_col), 64'd0);
      chk("post_rst_data", 64'(bus.data_out), 64'd4096);
      chk("post_rst_enable", 64'(bus.enable_out), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_gon_xbus

// File: doc/gon_xbus.md
Name: gon_xbus

Overview:
Column-level gather bus of the Global Output Network (GON), the return path opposite the GIN X-bus broadcast. Each of NUM_OF_COLS columns offers a psum word with enable/ready. The block forwards only from the column whose scan-programmed column ID matches col_tag, one word per transfer. Winners go through a single-entry registered output stage toward the GLB-side Y-bus.

Parameters:
DATA_WIDTH, 64, width of each psum word
COL_TAG_WIDTH, 4, width of col_tag and of each column ID
NUM_OF_COLS, 14, number of column inputs
SRC_WIDTH, $clog2(NUM_OF_COLS), width of out_col

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
data_in  input  [DATA_WIDTH-1:0] x [0:NUM_OF_COLS-1]  per-column psum
enable_in  input  [0:NUM_OF_COLS-1]  per-column valid
ready_out  output  [0:NUM_OF_COLS-1]  per-column accept
col_tag  input  COL_TAG_WIDTH  requested column ID, from the GON controller
data_out  output  DATA_WIDTH  registered gathered word
enable_out  output  1  data_out valid
ready_in  input  1  downstream accept
out_col  output  SRC_WIDTH  registered index of the source column
scan_en_id  input  1  ID scan shift enable
scan_in_id  input  1  scan chain input
scan_out_id  output  1  scan chain output

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - all col_id registers are 0
  - enable_out=0, data_out=0, out_col=0
  - round-robin pointer=0
  - ready_out=0 combinationally
- ID scan chain, one COL_TAG_WIDTH register per column:
  - When scan_en_id=1, each edge shifts one bit.
  - scan_in_id enters the LSB of col_id[0].
  - The MSB of col_id[i] feeds the LSB of col_id[i+1].
  - scan_out_id = MSB of col_id[NUM_OF_COLS-1], combinational.
  - Full load takes NUM_OF_COLS*COL_TAG_WIDTH cycles. Bits shifted in first end up in the last column.
- Match: match[i] = enable_in[i] && (col_id[i]==col_tag).
- Grant: exactly one index among match[], lowest index wins (fixed priority). grant_valid = |match.
- can_accept = !enable_out || ready_in.
- ready_out[i] = can_accept && !scan_en_id && grant_valid && (i==grant). At most one bit is high. ready_out depends combinationally on enable_in, col_tag and ready_in.
- A transfer occurs when enable_in[i] && ready_out[i]. On that edge:
  - data_out <= data_in[i]
  - out_col <= i
  - enable_out <= 1
- Latency: 1 cycle from the transfer edge to enable_out.
- With no transfer, if ready_in=1 then enable_out <= 0. Otherwise data_out, out_col and enable_out hold.
- data_out and out_col are stable while enable_out && !ready_in.
- Simultaneous drain and fill (enable_out && ready_in && transfer): the new word replaces the old and enable_out stays 1. This gives full throughput of 1 word/cycle.
- scan_en_id=1 blocks new transfers, but a pending output word still drains normally.
- col_tag matching no column, or a matching column with enable_in=0: no ready asserted, no state change.
- Duplicate IDs across columns are legal; arbitration resolves them.
- Reset mid-transfer drops the held word; columns must re-offer.

Optional Feature:
- Macro: GON_RR_ARB_EN.
- Defined: grant is round-robin among match[], starting the search at rr_ptr. On each transfer from column g, rr_ptr <= (g+1) mod NUM_OF_COLS. rr_ptr resets to 0.
- Undefined: fixed lowest-index priority and no rr_ptr register.

Decomposition:
- gon_pkg holds:
  - DATA_WIDTH/COL_TAG_WIDTH/NUM_OF_COLS defaults
  - typedefs col_id_t and psum_t
  - SRC_WIDTH function/localparam
- One sub-module, gon_col_arbiter. Inputs: match vector, transfer strobe. Outputs: grant index and grant_valid. It contains rr_ptr under GON_RR_ARB_EN.
- The scan chain and output register stay in gon_xbus.

Test Plan:
- Scan load: shift IDs so that col k gets ID k (14*4=56 cycles) -> scan_out_id replays the first-shifted bits after 56 cycles; col_tag=5 with enable_in[5]=1 gives ready_out=14'b00000100000000.
- Basic gather: col_tag=3, enable_in[3]=1, data_in[3]=64'hA5, ready_in=1 -> next cycle enable_out=1, data_out=64'hA5, out_col=3.
- Backpressure: ready_in=0 with the output full, col 3 offering 64'hB6 -> ready_out all 0; data_out holds 64'hA5 until ready_in=1, then 64'hB6 loads on that same edge.
- Duplicate IDs: cols 2 and 9 both ID 7, both enabled, col_tag=7 -> fixed mode: col 2 served every cycle. RR mode: out_col alternates 2,9,2,9.
- Scan blocks transfer: scan_en_id=1 with a match present -> ready_out=0; a pending word drains when ready_in=1.
- Async reset mid-stream: assert reset between edges while enable_out=1 -> enable_out, data_out and all IDs go to 0 immediately; col_tag=0 then matches all columns and col 0 wins.
